// File: rtl/mem_wb_if.sv
// mem_wb_if: bus between the EXE stage, the MEM/WB stage and the RF write port.
// The master drives the EXE result and consumes stall and the write-back
// request; the slave is the MEM/WB stage itself.
interface mem_wb_if #(
   parameter int RFW = 5,
   parameter int DW  = 32,
   parameter int IW  = 32
);
   logic           in_valid;
   logic [IW-1:0]  in_inst;
   logic [DW-1:0]  in_alu;
   logic [DW-1:0]  in_store;
   logic           stall;
   logic           wb_en;
   logic [RFW-1:0] wb_addr;
   logic [DW-1:0]  wb_data;

   modport master (
      output in_valid, in_inst, in_alu, in_store,
      input  stall, wb_en, wb_addr, wb_data
   );

   modport slave (
      input  in_valid, in_inst, in_alu, in_store,
      output stall, wb_en, wb_addr, wb_data
   );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: EXE/MEM buffer, word-addressed data memory with MEM_LAT-cycle
// occupancy, and registered write-back request for the register file.
// Optional feature macro: DM_BYTE_EN adds LB/SB byte-lane loads and stores;
// without it those opcodes are treated as bubbles.
module mem_wb_stage #(
   parameter int RFW     = 5,
   parameter int DMW     = 4,
   parameter int DW      = 32,
   parameter int IW      = 32,
   parameter int MEM_LAT = 2
) (
   input  logic     clk,
   input  logic     start,
   mem_wb_if.slave  bus
);

   localparam logic [5:0] OPC_LW  = 6'b100011;
   localparam logic [5:0] OPC_SW  = 6'b101011;
   localparam logic [5:0] OPC_NOP = 6'b111111;
   localparam logic [5:0] OPC_LB  = 6'b100000;
   localparam logic [5:0] OPC_SB  = 6'b101000;

   localparam int             CNTW = 4;
   localparam logic [CNTW-1:0] LAST = CNTW'(MEM_LAT - 1);

   typedef enum logic {S_IDLE, S_ACCESS} state_e;
   typedef enum logic [2:0] {K_BUBBLE, K_ALU, K_LW, K_SW, K_LB, K_SB} kind_e;

   function automatic logic is_mem(input kind_e k);
      return (k == K_LW) || (k == K_SW) || (k == K_LB) || (k == K_SB);
   endfunction

   state_e          state_q, state_d;
   logic [CNTW-1:0] cnt_q;
   kind_e           in_kind;
   kind_e           buf_kind_q;
   logic [RFW-1:0]  buf_rd_q;
   logic [DW-1:0]   buf_alu_q;
   logic [DW-1:0]   buf_store_q;
   logic            stall;
   logic            accept;
   logic            wb_en_q;
   logic [RFW-1:0]  wb_addr_q;
   logic [DW-1:0]   wb_data_q;

   logic [DW-1:0]   mem [2**DMW];
   logic [DMW-1:0]  mem_idx;
   logic [DW-1:0]   rd_word;
   logic [DW/8-1:0] mem_be;
   logic [DW-1:0]   mem_wdata;

   logic [5:0]      opcode;
   logic [RFW-1:0]  in_rd;
   logic            unused_inst_bits;

   assign opcode           = bus.in_inst[31:26];
   assign in_rd            = bus.in_inst[25 -: RFW];
   assign unused_inst_bits = ^bus.in_inst[25-RFW:0];

   assign mem_idx = buf_alu_q[DMW+1:2];
   assign rd_word = mem[mem_idx];

`ifdef DM_BYTE_EN
   logic [1:0] lane;
   logic [7:0] rd_byte;
   assign lane    = buf_alu_q[1:0];
   assign rd_byte = rd_word[{lane, 3'b000} +: 8];
`endif

   // Stall comes only from registered FSM state and counter.
   assign stall  = (state_q == S_ACCESS) && (cnt_q < LAST);
   assign accept = !stall;

   assign bus.stall   = stall;
   assign bus.wb_en   = wb_en_q;
   assign bus.wb_addr = wb_addr_q;
   assign bus.wb_data = wb_data_q;

   // Classify the incoming instruction into an operation kind.
   always_comb begin
      // NOTE: every variable written here gets a default first so no latch is inferred.
      in_kind = K_BUBBLE;
      if (bus.in_valid) begin
         case (opcode)
            OPC_LW:  in_kind = K_LW;
            OPC_SW:  in_kind = K_SW;
            OPC_NOP: in_kind = K_BUBBLE;
`ifdef DM_BYTE_EN
            OPC_LB:  in_kind = K_LB;
            OPC_SB:  in_kind = K_SB;
`else
            OPC_LB, OPC_SB: in_kind = K_BUBBLE;
`endif
            default: in_kind = K_ALU;
         endcase
      end
   end

   // Next FSM state: re-decided only when the buffer takes a new op.
   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = is_mem(in_kind) ? S_ACCESS : S_IDLE;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (start) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // EXE/MEM buffer and access counter.
   always_ff @(posedge clk) begin
      if (start) begin
         buf_kind_q  <= K_BUBBLE;
         buf_rd_q    <= '0;
         buf_alu_q   <= '0;
         buf_store_q <= '0;
         cnt_q       <= '0;
      end else if (accept) begin
         buf_kind_q  <= in_kind;
         buf_rd_q    <= in_rd;
         buf_alu_q   <= bus.in_alu;
         buf_store_q <= bus.in_store;
         cnt_q       <= '0;
      end else begin
         cnt_q <= cnt_q + 4'd1;
      end
   end

   // Byte-lane write enables for a retiring store; reset aborts it.
   always_comb begin
      mem_be    = '0;
      mem_wdata = buf_store_q;
      if (accept && !start) begin
         case (buf_kind_q)
            K_SW: mem_be = '1;
`ifdef DM_BYTE_EN
            K_SB: begin
               mem_be[lane] = 1'b1;
               mem_wdata    = {(DW/8){buf_store_q[7:0]}};
            end
`endif
            default: ;
         endcase
      end
   end

   // Data memory write port.
   always_ff @(posedge clk) begin
      // NOTE: the data memory has no reset; its contents survive start.
      for (int b = 0; b < DW/8; b++) begin
         if (mem_be[b]) mem[mem_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
   end

   // Write-back registers update whenever the buffer retires an op.
   always_ff @(posedge clk) begin
      if (start) begin
         wb_en_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
      end else if (accept) begin
         case (buf_kind_q)
            K_ALU: begin
               wb_en_q   <= (buf_rd_q != '0);
               wb_addr_q <= buf_rd_q;
               wb_data_q <= buf_alu_q;
            end
            K_LW: begin
               wb_en_q   <= (buf_rd_q != '0);
               wb_addr_q <= buf_rd_q;
               wb_data_q <= rd_word;
            end
`ifdef DM_BYTE_EN
            K_LB: begin
               wb_en_q   <= (buf_rd_q != '0);
               wb_addr_q <= buf_rd_q;
               wb_data_q <= {{(DW-8){rd_byte[7]}}, rd_byte};
            end
`endif
            default: wb_en_q <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed tests for mem_wb_stage with MEM_LAT=2, DMW=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_wb_stage;
   localparam int RFW = 5, DMW = 4, DW = 32, IW = 32, MEM_LAT = 2;

   localparam logic [5:0] OP_ADD = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_NOP = 6'b111111;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_SB  = 6'b101000;

   logic clk = 1'b0;
   logic start;
   int   n_checks = 0;
   int   n_pass   = 0;

   mem_wb_if #(.RFW(RFW), .DW(DW), .IW(IW)) bus ();

   mem_wb_stage #(.RFW(RFW), .DMW(DMW), .DW(DW), .IW(IW), .MEM_LAT(MEM_LAT)) dut (
      .clk   (clk),
      .start (start),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic put(input logic v, input logic [5:0] opc, input logic [4:0] rd,
                      input logic [31:0] alu, input logic [31:0] st);
      bus.in_valid = v;
      bus.in_inst  = {opc, rd, 21'h0};
      bus.in_alu   = alu;
      bus.in_store = st;
   endtask

   // Present an op, let it be captured, and return at the first falling edge
   // where the stage can accept again; stalls = falling edges seen with stall=1.
   task automatic issue(input logic v, input logic [5:0] opc, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] st, output int stalls);
      int n;
      put(v, opc, rd, alu, st);
      @(posedge clk);
      @(negedge clk);
      n = 0;
      while (bus.stall === 1'b1 && n < 20) begin
         n++;
         @(posedge clk);
         @(negedge clk);
      end
      if (bus.stall !== 1'b0) begin
         n_checks++;
         $display("FAIL stall_timeout: stall=%b after %0d cycles, want 0", bus.stall, n);
      end
      stalls = n;
   endtask

   task automatic bubble();
      int s;
      issue(1'b0, OP_NOP, 5'd0, 32'h0, 32'h0, s);
   endtask

   task automatic test_reset();
      start = 1'b1;
      put(1'b0, OP_NOP, 5'd0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n_checks++; if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.stall); else n_pass++;
      n_checks++; if (bus.wb_en !== 1'b0) $display("FAIL reset_wb_en: got %b want 0", bus.wb_en); else n_pass++;
      n_checks++; if (bus.wb_addr !== 5'd0) $display("FAIL reset_wb_addr: got %0d want 0", bus.wb_addr); else n_pass++;
      n_checks++; if (bus.wb_data !== 32'h0) $display("FAIL reset_wb_data: got %h want 0", bus.wb_data); else n_pass++;
   endtask

   task automatic test_alu();
      int s;
      issue(1'b1, OP_ADD, 5'd3, 32'h0000_0042, 32'h0, s);
      n_checks++; if (s !== 0) $display("FAIL alu_stall: got %0d want 0", s); else n_pass++;
      n_checks++; if (bus.wb_en !== 1'b0) $display("FAIL alu_early: wb_en got %b want 0 before retire", bus.wb_en); else n_pass++;
      bubble();
      n_checks++; if (bus.wb_en !== 1'b1) $display("FAIL alu_wb_en: got %b want 1", bus.wb_en); else n_pass++;
      n_checks++; if (bus.wb_addr !== 5'd3) $display("FAIL alu_wb_addr: got %0d want 3", bus.wb_addr); else n_pass++;
      n_checks++; if (bus.wb_data !== 32'h42) $display("FAIL alu_wb_data: got %h want 00000042", bus.wb_data); else n_pass++;
   endtask

   task automatic test_store_load();
      int s;
      issue(1'b1, OP_ADD, 5'd5, 32'h1, 32'h0, s);
      issue(1'b1, OP_SW, 5'd0, 32'h14, 32'hDEAD_BEEF, s);
      n_checks++; if (s !== 1) $display("FAIL sw_stall_cycles: got %0d want 1", s); else n_pass++;
      n_checks++; if (bus.wb_en !== 1'b1) $display("FAIL alu_before_sw: wb_en got %b want 1", bus.wb_en); else n_pass++;
      issue(1'b1, OP_LW, 5'd7, 32'h14, 32'h0, s);
      n_checks++; if (s !== 1) $display("FAIL lw_stall_cycles: got %0d want 1", s); else n_pass++;
      n_checks++; if (bus.wb_en !== 1'b0) $display("FAIL sw_wb_en: got %b want 0", bus.wb_en); else n_pass++;
      bubble();
      n_checks++; if (bus.wb_en !== 1'b1) $display("FAIL lw_wb_en: got %b want 1", bus.wb_en); else n_pass++;
      n_checks++; if (bus.wb_addr !== 5'd7) $display("FAIL lw_wb_addr: got %0d want 7", bus.wb_addr); else n_pass++;
      n_checks++; if (bus.wb_data !== 32'hDEAD_BEEF) $display("FAIL lw_wb_data: got %h want deadbeef", bus.wb_data); else n_pass++;
   endtask

   task automatic test_no_writeback();
      int s;
      issue(1'b1, OP_ADD, 5'd2, 32'h5, 32'h0, s);
      issue(1'b1, OP_ADD, 5'd0, 32'h99, 32'h0, s);
      bubble();
      n_checks++; if (bus.wb_en !== 1'b0) $display("FAIL alu_rd0: wb_en got %b want 0", bus.wb_en); else n_pass++;
      issue(1'b1, OP_ADD, 5'd2, 32'h5, 32'h0, s);
      issue(1'b0, OP_ADD, 5'd4, 32'h77, 32'h0, s);
      bubble();
      n_checks++; if (bus.wb_en !== 1'b0) $display("FAIL invalid_bubble: wb_en got %b want 0", bus.wb_en); else n_pass++;
      issue(1'b1, OP_ADD, 5'd2, 32'h5, 32'h0, s);
      issue(1'b1, OP_NOP, 5'd6, 32'h77, 32'h0, s);
      bubble();
      n_checks++; if (bus.wb_en !== 1'b0) $display("FAIL nop_bubble: wb_en got %b want 0", bus.wb_en); else n_pass++;
      issue(1'b1, OP_ADD, 5'd2, 32'h5, 32'h0, s);
      issue(1'b1, OP_LW, 5'd0, 32'h14, 32'h0, s);
      bubble();
      n_checks++; if (bus.wb_en !== 1'b0) $display("FAIL lw_rd0: wb_en got %b want 0", bus.wb_en); else n_pass++;
   endtask

   task automatic test_wrap();
      int s;
      issue(1'b1, OP_SW, 5'd0, 32'h40, 32'hA5A5_0001, s);
      issue(1'b1, OP_LW, 5'd9, 32'h00, 32'h0, s);
      bubble();
      n_checks++; if (bus.wb_data !== 32'hA5A5_0001) $display("FAIL wrap_word0: got %h want a5a50001", bus.wb_data); else n_pass++;
      issue(1'b1, OP_SW, 5'd0, 32'hFFFF_FF47, 32'h0BAD_CAFE, s);
      issue(1'b1, OP_LW, 5'd9, 32'h04, 32'h0, s);
      bubble();
      n_checks++; if (bus.wb_data !== 32'h0BAD_CAFE) $display("FAIL wrap_word1: got %h want 0badcafe", bus.wb_data); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int s;
      int stall_sum;
      stall_sum = 0;
      issue(1'b1, OP_ADD, 5'd1, 32'h11, 32'h0, s); stall_sum += s;
      issue(1'b1, OP_ADD, 5'd2, 32'h22, 32'h0, s); stall_sum += s;
      n_checks++; if (bus.wb_addr !== 5'd1 || bus.wb_data !== 32'h11) $display("FAIL b2b_first: got r%0d=%h want r1=00000011", bus.wb_addr, bus.wb_data); else n_pass++;
      issue(1'b1, OP_ADD, 5'd3, 32'h33, 32'h0, s); stall_sum += s;
      n_checks++; if (bus.wb_addr !== 5'd2 || bus.wb_data !== 32'h22) $display("FAIL b2b_second: got r%0d=%h want r2=00000022", bus.wb_addr, bus.wb_data); else n_pass++;
      bubble();
      n_checks++; if (bus.wb_addr !== 5'd3 || bus.wb_data !== 32'h33) $display("FAIL b2b_third: got r%0d=%h want r3=00000033", bus.wb_addr, bus.wb_data); else n_pass++;
      n_checks++; if (stall_sum !== 0) $display("FAIL b2b_stalls: got %0d want 0", stall_sum); else n_pass++;
   endtask

   task automatic test_reset_abort();
      int s;
      issue(1'b1, OP_SW, 5'd0, 32'h08, 32'hCAFE_F00D, s);
      bubble();
      put(1'b1, OP_SW, 5'd0, 32'h08, 32'h0000_1234);
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.stall !== 1'b1) $display("FAIL abort_pre_stall: got %b want 1", bus.stall); else n_pass++;
      start = 1'b1;
      put(1'b0, OP_NOP, 5'd0, 32'h0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n_checks++; if (bus.stall !== 1'b0) $display("FAIL abort_stall: got %b want 0", bus.stall); else n_pass++;
      issue(1'b1, OP_LW, 5'd10, 32'h08, 32'h0, s);
      bubble();
      n_checks++; if (bus.wb_data !== 32'hCAFE_F00D) $display("FAIL abort_mem: got %h want cafef00d", bus.wb_data); else n_pass++;
   endtask

   task automatic test_byte();
      int s;
      issue(1'b1, OP_SW, 5'd0, 32'h0, 32'h1122_3344, s);
      issue(1'b1, OP_ADD, 5'd13, 32'h1, 32'h0, s);
      issue(1'b1, OP_SB, 5'd0, 32'h2, 32'h0000_0080, s);
`ifdef DM_BYTE_EN
      n_checks++; if (s !== 1) $display("FAIL sb_stall_cycles: got %0d want 1", s); else n_pass++;
`else
      n_checks++; if (s !== 0) $display("FAIL sb_stall_cycles: got %0d want 0", s); else n_pass++;
`endif
      issue(1'b1, OP_LB, 5'd11, 32'h2, 32'h0, s);
      n_checks++; if (bus.wb_en !== 1'b0) $display("FAIL sb_wb_en: got %b want 0", bus.wb_en); else n_pass++;
      issue(1'b1, OP_LW, 5'd12, 32'h0, 32'h0, s);
`ifdef DM_BYTE_EN
      n_checks++; if (bus.wb_en !== 1'b1 || bus.wb_addr !== 5'd11) $display("FAIL lb_wb: got en=%b r%0d want en=1 r11", bus.wb_en, bus.wb_addr); else n_pass++;
      n_checks++; if (bus.wb_data !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h want ffffff80", bus.wb_data); else n_pass++;
`else
      n_checks++; if (bus.wb_en !== 1'b0) $display("FAIL lb_bubble: wb_en got %b want 0", bus.wb_en); else n_pass++;
`endif
      bubble();
`ifdef DM_BYTE_EN
      n_checks++; if (bus.wb_data !== 32'h1180_3344) $display("FAIL sb_word: got %h want 11803344", bus.wb_data); else n_pass++;
`else
      n_checks++; if (bus.wb_data !== 32'h1122_3344) $display("FAIL sb_word: got %h want 11223344", bus.wb_data); else n_pass++;
`endif
   endtask

   initial begin
      test_reset();
      test_alu();
      test_store_load();
      test_no_writeback();
      test_wrap();
      test_back_to_back();
      test_reset_abort();
      test_byte();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
